// File: rtl/abs_diff_sad_seq.sv
// abs_diff_sad_seq: time-shares one external combinational 8-bit abs_diff unit to compute
// the sum of absolute differences over a block of N_PAIRS operand pairs.
// Optional error monitor: define ABS_DIFF_ERRMON_EN to accumulate |exact - ad_r| into err_sum.
module abs_diff_sad_seq #(
  parameter int unsigned N_PAIRS = 16,
  parameter int unsigned ACC_W   = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       ad_a,
  output logic [7:0]       ad_b,
  input  logic [8:0]       ad_r,
  output logic             sad_valid,
  input  logic             sad_ready,
  output logic [ACC_W-1:0] sad,
  output logic [ACC_W-1:0] err_sum,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(N_PAIRS);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [7:0]       ad_a_q, ad_a_d, ad_b_q, ad_b_d;
  logic             s1_valid_q, s1_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d, sad_q, sad_d;
  logic             accept, acc_clr, acc_add;

  // Abort blocks acceptance in the same cycle so a discarded block never loads ad_a/ad_b.
  assign in_ready  = (state_q == StRun) && !abort;
  assign accept    = in_valid && in_ready;
  assign sad_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign ad_a      = ad_a_q;
  assign ad_b      = ad_b_q;
  assign sad       = sad_q;

  // Accumulator clear/add conditions shared with the error accumulator.
  assign acc_clr = abort || ((state_q == StIdle) && start);
  assign acc_add = s1_valid_q && (state_q != StIdle);

  // Accumulator next state: the pair registered last cycle is summed this cycle.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = '0;
    end else if (acc_add) begin
      acc_d = acc_q + ACC_W'(ad_r);
    end
    // Capture the final sum on the DRAIN->DONE step; held until the next block completes.
    sad_d = sad_q;
    if ((state_q == StDrain) && !abort) begin
      sad_d = acc_d;
    end
  end

  // Sequencer next state and operand registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s1_valid_d = 1'b0;
    ad_a_d     = ad_a_q;
    ad_b_d     = ad_b_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (accept) begin
          ad_a_d     = in_a;
          ad_b_d     = in_b;
          s1_valid_d = 1'b1;
          if (cnt_q == CntW'(N_PAIRS - 1)) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDrain: state_d = StDone;
      StDone: begin
        if (sad_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d    = StIdle;
      s1_valid_d = 1'b0;
      cnt_d      = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      ad_a_q     <= '0;
      ad_b_q     <= '0;
      acc_q      <= '0;
      sad_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      ad_a_q     <= ad_a_d;
      ad_b_q     <= ad_b_d;
      acc_q      <= acc_d;
      sad_q      <= sad_d;
    end
  end

`ifdef ABS_DIFF_ERRMON_EN
  logic [ACC_W-1:0] err_q, err_d;
  logic [8:0]       exact, err_pair;

  // Exact reference from the operand registers and per-pair deviation of the shared unit.
  always_comb begin
    exact    = (ad_a_q >= ad_b_q) ? {1'b0, ad_a_q - ad_b_q} : {1'b0, ad_b_q - ad_a_q};
    err_pair = (exact >= ad_r) ? (exact - ad_r) : (ad_r - exact);
    err_d    = err_q;
    if (acc_clr) begin
      err_d = '0;
    end else if (acc_add) begin
      err_d = err_q + ACC_W'(err_pair);
    end
  end

  // Error accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_sum = err_q;
`else
  assign err_sum = '0;
`endif

endmodule

// File: doc/abs_diff_sad_seq.md
Name: abs_diff_sad_seq

Overview:
- Sequencer that time-shares one combinational 8-bit abs_diff unit to compute the sum of absolute differences (SAD) over a block of N_PAIRS byte pairs.
- Accepts operand pairs on a valid/ready stream and drives the shared unit's a/b inputs from registers.
- Accumulates the unit's 9-bit result and presents the SAD on a valid/ready result port.
- Sits between a pixel-pair source and motion-estimation / error-metric logic; the unit may be exact or approximate and is instantiated outside this block.

Parameters:
- N_PAIRS, 16, pairs per SAD block (≥2).
- ACC_W, 13, accumulator and result width; must be ≥ 9 + clog2(N_PAIRS).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse; begins a block; honoured only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE and discards partial sum.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  operand pair accepted when in_valid & in_ready.
- in_a  input  8  operand a.
- in_b  input  8  operand b.
- ad_a  output  8  registered operand to the shared abs_diff unit.
- ad_b  output  8  registered operand to the shared abs_diff unit.
- ad_r  input  9  abs_diff result; combinational function of ad_a/ad_b.
- sad_valid  output  1  result valid.
- sad_ready  input  1  result consumer ready.
- sad  output  ACC_W  SAD result.
- err_sum  output  ACC_W  accumulated absolute error of ad_r vs exact (see Optional Feature).
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset values: state IDLE; ad_a=0, ad_b=0, acc=0, err acc=0, cnt=0, s1_valid=0; outputs in_ready=0, sad_valid=0, sad=0, err_sum=0, busy=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → acc=0, err acc=0, cnt=0, go to RUN.
- RUN:
  - in_ready=1.
  - On accept: ad_a<=in_a, ad_b<=in_b, s1_valid<=1, cnt<=cnt+1.
  - No accept: s1_valid<=0 and ad_a/ad_b hold their previous values (no toggling on the shared unit).
  - Accept with cnt==N_PAIRS-1 → DRAIN.
- Accumulate (any state except IDLE): each cycle with s1_valid=1, acc<=acc+zero-extended ad_r, i.e. the pair is summed in the cycle after it is accepted.
- DRAIN:
  - in_ready=0.
  - Final accumulate happens here; s1_valid<=0; go to DONE.
- DONE:
  - sad_valid=1; sad=acc and err_sum held stable until handshake.
  - sad_valid & sad_ready → IDLE, sad_valid=0 the next cycle.
  - in_ready=0; start ignored.
- Latency: sad_valid rises 2 cycles after the cycle that accepted the last pair; throughput 1 pair/cycle.
- start outside IDLE: ignored. start together with abort in IDLE: abort wins, stay in IDLE.
- abort in any state:
  - next cycle IDLE, s1_valid=0, sad_valid=0, acc cleared.
  - ad_a/ad_b hold; a pair offered in the same cycle is not accepted.
- rst mid-operation: identical effect to reset values above.
- Overflow: impossible within ACC_W constraint (max N_PAIRS*511); no saturation logic.
- sad output holds the last value after handshake until the next block's DONE.

Optional Feature:
- Macro: ABS_DIFF_ERRMON_EN.
- Defined:
  - Block computes exact |ad_a−ad_b| from its operand registers.
  - Each s1_valid cycle adds |exact−ad_r| into an err accumulator (ACC_W, same clear rules as acc).
  - err_sum drives that accumulator and is valid with sad_valid; used for characterising approximate abs_diff units.
- Undefined: no exact subtractor, no err accumulator; err_sum tied to 0.

Test Plan:
- Reset: assert rst 2 cycles mid-RUN → next cycle all outputs 0, state IDLE, busy=0; a following start produces a correct fresh SAD.
- Exact block: bench ad_r=|ad_a−ad_b|; start, 16 back-to-back pairs a=10,b=3 → sad=112, sad_valid exactly 2 cycles after 16th accept; err_sum=0.
- Gapped input: in_valid toggles every other cycle, 16 pairs a=200,b=0 → sad=3200; ad_a/ad_b unchanged on idle cycles.
- Result backpressure: sad_ready low 5 cycles in DONE → sad stable, in_ready=0, start pulse ignored; on sad_ready=1, one handshake then IDLE.
- Abort: abort after 7 accepted pairs → IDLE next cycle, no sad_valid; new block of 16 pairs a=1,b=2 → sad=16.
- Approx/error and max range:
  - Bench ad_r = exact with low 4 bits forced 0; 16 pairs a=7,b=0 → sad=0; err_sum=112 with ABS_DIFF_ERRMON_EN, 0 without.
  - Bench forces ad_r=511 for 16 pairs → sad=8176, no wrap.
